// File: rtl/req_grant_arbiter7_if.sv
// -----------------------------------------------------------------------------
// req_grant_arbiter7_if
// Request/grant bundle between up to seven masters and the arbiter.
//   req          7  level requests, req[i] from master i
//   grant        7  registered one-hot grant, zero when idle
//   grant_valid  1  registered, high iff grant is non-zero
//   grant_idx    3  registered binary index of the current owner
//   any_req      1  combinational OR of all request lines
//   timeout      1  registered one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface req_grant_arbiter7_if;
    logic [6:0] req;
    logic [6:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       any_req;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  any_req,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output any_req,
        output timeout
    );
endinterface

// File: rtl/req_grant_arbiter7.sv
// -----------------------------------------------------------------------------
// req_grant_arbiter7
// Seven-way round-robin arbiter sharing one resource among up to seven
// masters. A winner keeps the grant while its request stays high, for at
// most HOLD_MAX consecutive cycles; every release is followed by exactly one
// idle (GAP) cycle before the next arbitration.
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of req_grant_arbiter7_if (req in; grant, grant_valid,
//         grant_idx, timeout registered out; any_req combinational out)
// -----------------------------------------------------------------------------
module req_grant_arbiter7 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    req_grant_arbiter7_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

    state_t           state_r;
    state_t           next_state_s;
    logic [6:0]       grant_r;
    logic [6:0]       grant_nxt_s;
    logic             valid_r;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [2:0]       last_ptr_r;
    logic [2:0]       last_ptr_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_nxt_s;
    logic             timeout_r;
    logic             timeout_nxt_s;
    logic [7:0]       req_ext_s;
    logic [3:0]       pick_s;

    // Round-robin search: scan last+1 .. last+7 (mod 7), first request wins.
    // Result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] req_v,
                                           input logic [2:0] last);
        logic [3:0] pick;
        logic [3:0] pos;
        pick = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            pos = {1'b0, last} + 4'(k);
            if (pos >= 4'd7) begin
                pos = pos - 4'd7;
            end else begin
                pos = pos;
            end
            if (!pick[3] && req_v[pos[2:0]]) begin
                pick = {1'b1, pos[2:0]};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Pad requests to 8 bits so a 3-bit index is always in range.
    assign req_ext_s = {1'b0, bus.req};
    assign pick_s    = rr_pick(req_ext_s, last_ptr_r);

    // Next-state and next-output logic.
    always_comb begin
        next_state_s   = state_r;
        grant_nxt_s    = grant_r;
        idx_nxt_s      = idx_r;
        last_ptr_nxt_s = last_ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (pick_s[3]) begin
                    next_state_s   = ST_GRANT;
                    grant_nxt_s    = 7'(7'd1 << pick_s[2:0]);
                    idx_nxt_s      = pick_s[2:0];
                    last_ptr_nxt_s = pick_s[2:0];
                    hold_cnt_nxt_s = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    next_state_s   = ST_IDLE;
                    grant_nxt_s    = 7'd0;
                    idx_nxt_s      = 3'd0;
                    hold_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_GRANT: begin
                // Owner release has priority over the hold-limit timeout.
                if (!req_ext_s[idx_r]) begin
                    next_state_s   = ST_GAP;
                    grant_nxt_s    = 7'd0;
                    idx_nxt_s      = 3'd0;
                    hold_cnt_nxt_s = {CNT_W{1'b0}};
                end else if (hold_cnt_r == HOLD_MAX_C) begin
                    next_state_s   = ST_GAP;
                    grant_nxt_s    = 7'd0;
                    idx_nxt_s      = 3'd0;
                    hold_cnt_nxt_s = {CNT_W{1'b0}};
                    timeout_nxt_s  = 1'b1;
                end else begin
                    next_state_s   = ST_GRANT;
                    hold_cnt_nxt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                next_state_s   = ST_IDLE;
                grant_nxt_s    = 7'd0;
                idx_nxt_s      = 3'd0;
                hold_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= 7'd0;
            valid_r    <= 1'b0;
            idx_r      <= 3'd0;
            last_ptr_r <= 3'd6;
            hold_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            grant_r    <= grant_nxt_s;
            valid_r    <= |grant_nxt_s;
            idx_r      <= idx_nxt_s;
            last_ptr_r <= last_ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = valid_r;
    assign bus.grant_idx   = idx_r;
    assign bus.timeout     = timeout_r;
    assign bus.any_req     = |bus.req;

endmodule
